// File: rtl/divider_seq_restoring.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands and results.
module divider_seq_restoring #(
  parameter int BITWIDTH = 8
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                START,
  input  logic [BITWIDTH-1:0] DIVIDEND,
  input  logic [BITWIDTH-1:0] DIVISOR,
  output logic [BITWIDTH-1:0] QUOTIENT,
  output logic [BITWIDTH-1:0] REMAINDER,
  output logic                BUSY,
  output logic                DONE,
  output logic                DIV_ZERO
);

  localparam int W  = BITWIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t state, state_d;

  logic [W-1:0]  pr, pr_d;
  logic [W-1:0]  wq, wq_d;
  logic [W-1:0]  dvs, dvs_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [W-1:0]  quo_d, rem_d;
  logic          busy_d, done_d, dz_d;

  logic [W:0]    sh, nb;
  logic [W+1:0]  c;
  logic [W-1:0]  t;
  logic          borrow;
  logic [W-1:0]  pr_n, wq_n;
  logic [W-1:0]  q_fin, r_fin;
  logic [W-1:0]  dvd_mag, dvs_mag, zero_rem;
  logic          last, dvs_zero;

`ifdef DIV_SIGNED_EN
  logic [W-1:0]  dvd_raw, dvd_raw_d;
  logic          neg_q, neg_q_d;
  logic          neg_r, neg_r_d;
`endif

  // Trial subtraction on an explicit ripple chain: sh + ~dvs + 1
  always_comb begin
    sh   = {pr, wq[W-1]};
    nb   = ~{1'b0, dvs};
    c    = '0;
    c[0] = 1'b1;
    t    = '0;
    for (int i = 0; i < W; i++) begin
      t[i]   = sh[i] ^ nb[i] ^ c[i];
      c[i+1] = (sh[i] & nb[i])
             | (c[i] & (sh[i] ^ nb[i]));
    end
    c[W+1] = (sh[W] & nb[W])
           | (c[W] & (sh[W] ^ nb[W]));
    borrow = ~c[W+1];
    pr_n   = borrow ? sh[W-1:0] : t;
    wq_n   = {wq[W-2:0], ~borrow};
  end

  assign last     = (cnt == CW'(W - 1));
  assign dvs_zero = (dvs == '0);

`ifdef DIV_SIGNED_EN
  always_comb begin
    dvd_mag  = DIVIDEND[W-1] ? (~DIVIDEND + ONE)
                             : DIVIDEND;
    dvs_mag  = DIVISOR[W-1] ? (~DIVISOR + ONE)
                            : DIVISOR;
    q_fin    = neg_q ? (~wq_n + ONE) : wq_n;
    r_fin    = neg_r ? (~pr_n + ONE) : pr_n;
    zero_rem = dvd_raw;
  end
`else
  always_comb begin
    dvd_mag  = DIVIDEND;
    dvs_mag  = DIVISOR;
    q_fin    = wq_n;
    r_fin    = pr_n;
    zero_rem = wq;
  end
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (START) state_d = CALC;
      CALC:    if (dvs_zero || last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pr_d   = pr;
    wq_d   = wq;
    dvs_d  = dvs;
    cnt_d  = cnt;
    quo_d  = QUOTIENT;
    rem_d  = REMAINDER;
    busy_d = BUSY;
    done_d = 1'b0;
    dz_d   = DIV_ZERO;
`ifdef DIV_SIGNED_EN
    dvd_raw_d = dvd_raw;
    neg_q_d   = neg_q;
    neg_r_d   = neg_r;
`endif
    unique case (1'b1)
      (state == IDLE && START): begin
        pr_d   = '0;
        wq_d   = dvd_mag;
        dvs_d  = dvs_mag;
        cnt_d  = '0;
        busy_d = 1'b1;
        dz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
        dvd_raw_d = DIVIDEND;
        neg_q_d   = DIVIDEND[W-1] ^ DIVISOR[W-1];
        neg_r_d   = DIVIDEND[W-1];
`endif
      end
      (state == CALC && dvs_zero): begin
        quo_d  = '1;
        rem_d  = zero_rem;
        dz_d   = 1'b1;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      (state == CALC && !dvs_zero): begin
        pr_d  = pr_n;
        wq_d  = wq_n;
        cnt_d = cnt + CW'(1);
        if (last) begin
          quo_d  = q_fin;
          rem_d  = r_fin;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pr        <= '0;
      wq        <= '0;
      dvs       <= '0;
      cnt       <= '0;
      QUOTIENT  <= '0;
      REMAINDER <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      DIV_ZERO  <= 1'b0;
`ifdef DIV_SIGNED_EN
      dvd_raw   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      pr        <= pr_d;
      wq        <= wq_d;
      dvs       <= dvs_d;
      cnt       <= cnt_d;
      QUOTIENT  <= quo_d;
      REMAINDER <= rem_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      DIV_ZERO  <= dz_d;
`ifdef DIV_SIGNED_EN
      dvd_raw   <= dvd_raw_d;
      neg_q     <= neg_q_d;
      neg_r     <= neg_r_d;
`endif
    end
  end

endmodule

// File: tb/tb_divider_seq_restoring.sv
// Directed bench for divider_seq_restoring at BITWIDTH=8.
// Signed vectors run only when DIV_SIGNED_EN is defined.
module tb_divider_seq_restoring;

  logic       CLK;
  logic       nRST;
  logic       START;
  logic [7:0] DIVIDEND;
  logic [7:0] DIVISOR;
  logic [7:0] QUOTIENT;
  logic [7:0] REMAINDER;
  logic       BUSY;
  logic       DONE;
  logic       DIV_ZERO;

  int checks = 0;
  int errors = 0;

  divider_seq_restoring #(.BITWIDTH(8)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .START(START),
    .DIVIDEND(DIVIDEND),
    .DIVISOR(DIVISOR),
    .QUOTIENT(QUOTIENT),
    .REMAINDER(REMAINDER),
    .BUSY(BUSY),
    .DONE(DONE),
    .DIV_ZERO(DIV_ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [7:0] a,
                       input logic [7:0] b);
    DIVIDEND = a;
    DIVISOR  = b;
    START    = 1'b1;
    tick();
    START    = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!DONE && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    nRST  = 1'b0;
    START = 1'b0;
    tick();
    tick();
    checks++;
    if ({QUOTIENT, REMAINDER} !== 16'h0) begin
      errors++;
      $display("FAIL reset_qr got %h want 0000",
               {QUOTIENT, REMAINDER});
    end
    checks++;
    if ({BUSY, DONE, DIV_ZERO} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000",
               {BUSY, DONE, DIV_ZERO});
    end
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    int lat;
    int busy_n;
    issue(8'd100, 8'd7);
    busy_n = 0;
    lat = 0;
    while (!DONE && lat < 40) begin
      if (BUSY) busy_n++;
      tick();
      lat++;
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL nom_latency got %0d want 8", lat);
    end
    checks++;
    if (busy_n !== 8) begin
      errors++;
      $display("FAIL nom_busy got %0d want 8", busy_n);
    end
    checks++;
    if ({QUOTIENT, REMAINDER, DIV_ZERO, BUSY}
        !== {8'd14, 8'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL nom_result got %0d r %0d dz %b b %b want 14 r 2 dz 0 b 0",
               QUOTIENT, REMAINDER, DIV_ZERO, BUSY);
    end
    tick();
    checks++;
    if ({DONE, QUOTIENT, REMAINDER}
        !== {1'b0, 8'd14, 8'd2}) begin
      errors++;
      $display("FAIL nom_hold got d %b %0d r %0d want d 0 14 r 2",
               DONE, QUOTIENT, REMAINDER);
    end
  endtask

  task automatic test_edges();
    int lat;
    issue(8'd255, 8'd1);
    wait_done(lat);
    checks++;
    if ({lat[7:0], QUOTIENT, REMAINDER}
        !== {8'd8, 8'd255, 8'd0}) begin
      errors++;
      $display("FAIL edge_255_1 got lat %0d %0d r %0d want 8 255 r 0",
               lat, QUOTIENT, REMAINDER);
    end
    tick();
    issue(8'd3, 8'd10);
    wait_done(lat);
    checks++;
    if ({lat[7:0], QUOTIENT, REMAINDER}
        !== {8'd8, 8'd0, 8'd3}) begin
      errors++;
      $display("FAIL edge_3_10 got lat %0d %0d r %0d want 8 0 r 3",
               lat, QUOTIENT, REMAINDER);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(8'd255, 8'd1);
    wait_done(lat);
    DIVIDEND = 8'd200;
    DIVISOR  = 8'd200;
    START    = 1'b1;
    tick();
    START    = 1'b0;
    checks++;
    if ({BUSY, DONE, QUOTIENT}
        !== {1'b1, 1'b0, 8'd255}) begin
      errors++;
      $display("FAIL b2b_accept got b %b d %b q %0d want b 1 d 0 q 255",
               BUSY, DONE, QUOTIENT);
    end
    wait_done(lat);
    checks++;
    if ({lat[7:0], QUOTIENT, REMAINDER}
        !== {8'd8, 8'd1, 8'd0}) begin
      errors++;
      $display("FAIL b2b_result got lat %0d %0d r %0d want 8 1 r 0",
               lat, QUOTIENT, REMAINDER);
    end
    tick();
  endtask

  task automatic test_div_zero();
    int lat;
    issue(8'd5, 8'd0);
    wait_done(lat);
    checks++;
    if ({lat[7:0], QUOTIENT, REMAINDER, DIV_ZERO, BUSY}
        !== {8'd1, 8'hFF, 8'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dz_result got lat %0d %h r %0d dz %b b %b want 1 ff r 5 dz 1 b 0",
               lat, QUOTIENT, REMAINDER, DIV_ZERO, BUSY);
    end
    tick();
    checks++;
    if ({DONE, DIV_ZERO} !== 2'b01) begin
      errors++;
      $display("FAIL dz_hold got d %b dz %b want d 0 dz 1",
               DONE, DIV_ZERO);
    end
    issue(8'd9, 8'd3);
    checks++;
    if (DIV_ZERO !== 1'b0) begin
      errors++;
      $display("FAIL dz_clear got %b want 0", DIV_ZERO);
    end
    wait_done(lat);
    checks++;
    if ({lat[7:0], QUOTIENT, REMAINDER, DIV_ZERO}
        !== {8'd8, 8'd3, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL dz_next got lat %0d %0d r %0d dz %b want 8 3 r 0 dz 0",
               lat, QUOTIENT, REMAINDER, DIV_ZERO);
    end
    tick();
  endtask

  task automatic test_start_busy();
    int done_n;
    int lat;
    logic [7:0] q, r;
    done_n = 0;
    lat = 0;
    q = '0;
    r = '0;
    issue(8'd100, 8'd7);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (cyc == 3) begin
        DIVIDEND = 8'd50;
        DIVISOR  = 8'd5;
        START    = 1'b1;
      end
      tick();
      START = 1'b0;
      if (DONE) begin
        done_n++;
        if (done_n == 1) begin
          lat = cyc;
          q = QUOTIENT;
          r = REMAINDER;
        end
      end
    end
    checks++;
    if (done_n !== 1) begin
      errors++;
      $display("FAIL busy_done_count got %0d want 1", done_n);
    end
    checks++;
    if ({lat[7:0], q, r} !== {8'd8, 8'd14, 8'd2}) begin
      errors++;
      $display("FAIL busy_result got lat %0d %0d r %0d want 8 14 r 2",
               lat, q, r);
    end
  endtask

  task automatic test_reset_mid();
    int done_n;
    int lat;
    issue(8'd100, 8'd7);
    tick();
    tick();
    tick();
    nRST = 1'b0;
    tick();
    checks++;
    if ({QUOTIENT, REMAINDER, BUSY, DONE, DIV_ZERO}
        !== 19'h0) begin
      errors++;
      $display("FAIL rst_mid got q %0d r %0d b %b d %b dz %b want all 0",
               QUOTIENT, REMAINDER, BUSY, DONE, DIV_ZERO);
    end
    nRST = 1'b1;
    done_n = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      if (DONE || BUSY) done_n++;
    end
    checks++;
    if (done_n !== 0) begin
      errors++;
      $display("FAIL rst_no_done got %0d active cycles want 0", done_n);
    end
    issue(8'd77, 8'd8);
    wait_done(lat);
    checks++;
    if ({lat[7:0], QUOTIENT, REMAINDER}
        !== {8'd8, 8'd9, 8'd5}) begin
      errors++;
      $display("FAIL rst_after got lat %0d %0d r %0d want 8 9 r 5",
               lat, QUOTIENT, REMAINDER);
    end
    tick();
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    int lat;
    issue(8'h9C, 8'd7);
    wait_done(lat);
    checks++;
    if ({lat[7:0], QUOTIENT, REMAINDER}
        !== {8'd8, 8'hF2, 8'hFE}) begin
      errors++;
      $display("FAIL sgn_m100_7 got lat %0d %h r %h want 8 f2 r fe",
               lat, QUOTIENT, REMAINDER);
    end
    tick();
    issue(8'd100, 8'hF9);
    wait_done(lat);
    checks++;
    if ({lat[7:0], QUOTIENT, REMAINDER}
        !== {8'd8, 8'hF2, 8'h02}) begin
      errors++;
      $display("FAIL sgn_100_m7 got lat %0d %h r %h want 8 f2 r 02",
               lat, QUOTIENT, REMAINDER);
    end
    tick();
    issue(8'h80, 8'hFF);
    wait_done(lat);
    checks++;
    if ({lat[7:0], QUOTIENT, REMAINDER, DIV_ZERO}
        !== {8'd8, 8'h80, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL sgn_min_m1 got lat %0d %h r %h dz %b want 8 80 r 00 dz 0",
               lat, QUOTIENT, REMAINDER, DIV_ZERO);
    end
    tick();
  endtask
`endif

  initial begin
    nRST     = 1'b0;
    START    = 1'b0;
    DIVIDEND = '0;
    DIVISOR  = '0;
    test_reset();
    test_nominal();
    test_edges();
    test_back_to_back();
    test_div_zero();
    test_start_busy();
    test_reset_mid();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
